bch_error_parallel: RTL and testbench
=====================================

Name: bch_error_parallel

Overview:
- Next-generation Chien search for the BCH decoder.
- Evaluates the error-locator polynomial sigma(x) at P data-bit locations per cycle rather than one.
- Output beats stall under downstream backpressure; data bits beyond K on the last beat are masked.
- Counts corrected bits and flags decode failure (roots found != deg sigma).
- Sits between the Berlekamp/sigma stage and the data-correction XOR stage.

Parameters:
M, 4, field degree; N = 2^M-1
K, 5, data bits per codeword; 1 <= K <= N-M
T, 2, correctable errors; sigma has T+1 coefficients
P, 2, locations evaluated per beat; 1 <= P <= K

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  load sigma and begin search; honoured only when busy=0
sigma  in  M*(T+1)  sigma coefficients, sigma[i*M+:M] = sigma_i, sigma_0 = 1
accepted  in  1  downstream takes the current beat when valid=1
busy  out  1  search in progress, from the cycle after start until the last beat is accepted
ready  out  1  one-cycle pulse coincident with the first valid beat
valid  out  1  err/err_count are a current beat
err  out  P  err[j]=1 means data bit n*P+j is in error (n = beat index)
err_count  out  clog2(T+1)+1  running count of flagged bits, including the current beat
done  out  1  one-cycle pulse when the last beat is accepted
fail  out  1  qualified by done: roots found != deg(sigma)

Behaviour:
- Reset values: all outputs 0, all internal registers 0, FSM in IDLE. Reset mid-search aborts immediately with no done pulse.
- Constants:
  - SHIFT = N-K; data bit b is tested at x = alpha^(b+SHIFT).
  - NBEATS = ceil(K/P).
  - LASTMASK = lanes j < K-(NBEATS-1)*P.
- FSM states IDLE, PRIME, RUN.
- IDLE:
  - On start, latch z_i <= sigma_i for i = 0..T.
  - Latch deg = highest i with sigma_i != 0.
  - Clear err_count and the beat counter; busy<=1; go to PRIME.
- PRIME (1 cycle): z_i <= z_i*alpha^(i*SHIFT) via constant multipliers; go to RUN; valid<=1 and ready<=1 on the next edge.
- RUN:
  - Combinational lanes compute e_j = sum_i z_i*alpha^(i*j) for j = 0..P-1.
  - err[j] = (e_j == 0) && valid && lane j enabled; lanes outside LASTMASK are disabled on the last beat.
  - err_count shows the accumulated count plus popcount(err) for the current beat.
  - Hold: while valid && !accepted, z, err, err_count and the beat counter hold.
  - Advance: on valid && accepted, z_i <= z_i*alpha^(i*P), the accumulator adds popcount(err), and the beat counter increments.
  - Last beat accepted: done=1 and fail=(final err_count != deg) in that cycle, held only for that cycle; next edge busy<=0, valid<=0, go to IDLE.
- start during PRIME/RUN is ignored; a start in the cycle busy falls is accepted.
- err_count saturates at 2^width-1 (cannot exceed T+... if sigma is consistent; saturation is a safety net only).
- deg = 0 (sigma = 1): no errors expected, fail=0 if none flagged.
- T = 1 needs no special case; the generic sum is used.
- Roots in parity positions are not searched, so they appear as fail=1. This is the intended behaviour; the consumer treats fail as uncorrectable.
- All field multiplies are constant-by-variable in standard basis with the default primitive polynomial from bch.vh.

Decomposition:
- Shared header bch.vh gains:
  - lpow-based helper for alpha^(i*SHIFT) and alpha^(i*P) constants;
  - clog2;
  - a popcount function over P bits.
- Sub-module chien_reg_scaled holds one coefficient register z_i with load, prime (x alpha^(i*SHIFT)) and step (x alpha^(i*P)) enables. It is instantiated T+1 times.
- Lane evaluation and the FSM stay in the top module.

Test Plan:
1. M=4,K=5,T=2,P=2, sigma={0,0,1}.
   - Required: 3 beats with err=00,00,00; ready with beat 0; done after 3rd accept, err_count=0, fail=0.
2. sigma_1=0x4, sigma_2=0 (root at bit 3), accepted=1 always.
   - Required: beat1 err=2'b10; final err_count=1; fail=0; busy low 1 cycle after done.
3. sigma_1=0x4, sigma_2=0xC (bits 0 and 4).
   - Required: beat0 err=01, beat2 err=01 with lane1 masked; err_count=2; fail=0.
4. sigma_1=0, sigma_2=1 (double root at x=1, a parity location).
   - Required: no err bits; err_count=0; fail=1 with done.
5. Case 3 with accepted low for 4 cycles on beat 1.
   - Required: err/err_count/valid stable while stalled; final result identical to case 3.
   - Also: start asserted mid-run is ignored.
6. Assert reset during beat 1 of case 3, then start case 2.
   - Required: all outputs 0 immediately, no done pulse; the new search gives case 2 results exactly.

Source files
------------

// File: rtl/bch_error_parallel_pkg.sv
// Shared constants, types and GF(2^M) helpers for the parallel Chien search.
package bch_error_parallel_pkg;

  localparam int M = 4;
  localparam int K = 5;
  localparam int T = 2;
  localparam int P = 2;

  localparam int N = (1 << M) - 1;
  // Primitive polynomial x^4 + x + 1
  localparam logic [M:0] PRIM_POLY = 5'b10011;

  // Data bit b sits at field location alpha^(b+SHIFT)
  localparam int SHIFT      = N - K;
  localparam int NBEATS     = (K + P - 1) / P;
  localparam int LAST_LANES = K - (NBEATS - 1) * P;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  localparam int CW = clog2(T + 1) + 1;
  localparam int BW = clog2(NBEATS) + 1;

  typedef logic [M-1:0] gf_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Multiply by alpha: shift up and reduce by the primitive polynomial
  function automatic gf_t gf_mul_alpha(input gf_t a);
    gf_t r;
    r = {a[M-2:0], 1'b0};
    if (a[M-1]) r = r ^ PRIM_POLY[M-1:0];
    return r;
  endfunction

  // Standard-basis multiply; with one constant operand this folds to XORs
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t r;
    gf_t x;
    r = '0;
    x = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) r = r ^ x;
      x = gf_mul_alpha(x);
    end
    return r;
  endfunction

  // alpha^e for any non-negative e
  function automatic gf_t gf_alpha_pow(input int e);
    gf_t r;
    int  em;
    r  = gf_t'(1);
    em = e % N;
    for (int k = 0; k < N; k++) begin
      if (k < em) r = gf_mul_alpha(r);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [P-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < P; k++) c = c + CW'(v[k]);
    return c;
  endfunction

endpackage

// File: rtl/bch_error_parallel_chien_reg_scaled.sv
// One sigma coefficient register z_i: load, prime by alpha^(i*SHIFT),
// step by alpha^(i*P).
module bch_error_parallel_chien_reg_scaled
  import bch_error_parallel_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [M-1:0] i_load_val,
  input  logic         i_prime,
  input  logic         i_step,
  output logic [M-1:0] o_z
);

  localparam gf_t PRIME_C = gf_alpha_pow(IDX * SHIFT);
  localparam gf_t STEP_C  = gf_alpha_pow(IDX * P);

  gf_t r_z;

  // Coefficient register: load wins, then prime, then step, else hold
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_z <= '0;
    end else if (i_load) begin
      r_z <= i_load_val;
    end else if (i_prime) begin
      r_z <= gf_mul(r_z, PRIME_C);
    end else if (i_step) begin
      r_z <= gf_mul(r_z, STEP_C);
    end
  end

  assign o_z = r_z;

endmodule

// File: rtl/bch_error_parallel.sv
// Parallel Chien search: evaluates sigma(x) at P data-bit locations per beat,
// stalls under backpressure, counts roots and flags decode failure.
module bch_error_parallel
  import bch_error_parallel_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [M*(T+1)-1:0]   i_sigma,
  input  logic                 i_accepted,
  output logic                 o_busy,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [P-1:0]         o_err,
  output logic [CW-1:0]        o_err_count,
  output logic                 o_done,
  output logic                 o_fail
);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_busy;
  logic            r_valid;
  logic            r_ready;
  logic [CW-1:0]   r_acc;
  logic [CW-1:0]   r_deg;
  logic [BW-1:0]   r_beat;

  logic            w_load;
  logic            w_prime;
  logic            w_step;
  logic            w_done;
  logic            w_last;
  gf_t             w_z [0:T];
  logic [CW-1:0]   w_deg;
  logic [P-1:0]    w_err;
  logic [CW:0]     w_sum;
  logic [CW-1:0]   w_err_count;

  genvar gi;

  generate
    for (gi = 0; gi <= T; gi++) begin : g_coef
      bch_error_parallel_chien_reg_scaled #(
        .IDX(gi)
      ) u_reg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (i_sigma[gi*M +: M]),
        .i_prime    (w_prime),
        .i_step     (w_step),
        .o_z        (w_z[gi])
      );
    end
  endgenerate

  assign w_last = (r_beat == BW'(NBEATS - 1));

  generate
    for (gi = 0; gi < P; gi++) begin : g_lane
      gf_t  w_e;
      logic w_en;

      // Lane gi evaluates sum_i z_i * alpha^(i*gi)
      always_comb begin
        w_e = '0;
        for (int i = 0; i <= T; i++) begin
          w_e = w_e ^ gf_mul(w_z[i], gf_alpha_pow(i * gi));
        end
      end

      // Lanes past the last data bit are disabled on the final beat
      assign w_en       = !w_last || (gi < LAST_LANES);
      assign w_err[gi]  = r_valid && w_en && (w_e == '0);
    end
  endgenerate

  // Running count including the current beat, saturating as a safety net
  always_comb begin
    w_sum       = {1'b0, r_acc} + {1'b0, popcount(w_err)};
    w_err_count = w_sum[CW] ? '1 : w_sum[CW-1:0];
  end

  // Degree of the incoming sigma: highest non-zero coefficient index
  always_comb begin
    w_deg = '0;
    for (int i = 1; i <= T; i++) begin
      if (i_sigma[i*M +: M] != '0) w_deg = CW'(i);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_prime      = 1'b0;
    w_step       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = ST_PRIME;
        end
      end
      ST_PRIME: begin
        w_prime      = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_valid && i_accepted) begin
          w_step = 1'b1;
          if (w_last) begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status flags, beat counter and count accumulator
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_acc   <= '0;
      r_deg   <= '0;
      r_beat  <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_load) begin
        r_acc  <= '0;
        r_beat <= '0;
        r_deg  <= w_deg;
        r_busy <= 1'b1;
      end
      if (w_prime) begin
        r_valid <= 1'b1;
        r_ready <= 1'b1;
      end
      if (w_step) begin
        r_acc  <= w_err_count;
        r_beat <= r_beat + 1'b1;
      end
      if (w_done) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_err       = w_err;
  assign o_err_count = w_err_count;
  assign o_done      = w_done;
  assign o_fail      = w_done && (w_err_count != r_deg);

endmodule

// File: tb/tb_bch_error_parallel.sv
// Self-checking bench for bch_error_parallel (M=4, K=5, T=2, P=2).
module tb_bch_error_parallel;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] sigma;
  logic        accepted;
  logic        busy, ready, valid, done, fail;
  logic [1:0]  err;
  logic [2:0]  err_count;

  int checks = 0;
  int errors = 0;

  int exp_t [0:14];
  int log_t [0:15];

  // Observations from the most recent search
  logic [1:0] obs_err [0:2];
  logic [2:0] obs_cnt [0:2];
  int         obs_beats;
  int         obs_done_cnt;
  int         obs_done_beat;
  logic       obs_fail;
  logic [2:0] obs_final;
  logic       obs_busy_after;
  logic       obs_busy_during;
  logic       obs_unstable;
  logic       obs_ready_bad;
  logic       obs_timeout;

  always #5 clk = ~clk;

  bch_error_parallel dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_sigma     (sigma),
    .i_accepted  (accepted),
    .o_busy      (busy),
    .o_ready     (ready),
    .o_valid     (valid),
    .o_err       (err),
    .o_err_count (err_count),
    .o_done      (done),
    .o_fail      (fail)
  );

  // ---------------- reference model (log/antilog GF(16)) ----------------
  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 15];
  endfunction

  function automatic bit is_root(input logic [11:0] sig, input int b);
    int e;
    int s;
    e = (b + 10) % 15;
    s = 0;
    for (int i = 0; i < 3; i++) s = s ^ gmul(int'(sig[i*4 +: 4]), exp_t[(e * i) % 15]);
    return s == 0;
  endfunction

  function automatic logic [1:0] model_err(input logic [11:0] sig, input int n);
    logic [1:0] r;
    r = 2'b00;
    for (int j = 0; j < 2; j++) begin
      if (n * 2 + j < 5 && is_root(sig, n * 2 + j)) r[j] = 1'b1;
    end
    return r;
  endfunction

  function automatic int model_count(input logic [11:0] sig, input int n);
    int c;
    logic [1:0] e;
    c = 0;
    for (int k = 0; k <= n; k++) begin
      e = model_err(sig, k);
      c = c + int'(e[0]) + int'(e[1]);
    end
    return (c > 7) ? 7 : c;
  endfunction

  function automatic int model_deg(input logic [11:0] sig);
    int d;
    d = 0;
    for (int i = 1; i < 3; i++) if (sig[i*4 +: 4] != 4'h0) d = i;
    return d;
  endfunction

  // ---------------- stimulus: one full search ----------------
  // mode 0: always accept; 1: stall beat 1 for 4 cycles with start held high;
  // 2: random accept
  task automatic run_search(input logic [11:0] sig, input int mode);
    int   cyc;
    int   stall;
    bit   finished;
    bit   first_valid;
    bit   prev_hold;
    logic [1:0] prev_err;
    logic [2:0] prev_cnt;
    obs_beats = 0; obs_done_cnt = 0; obs_done_beat = -1; obs_fail = 1'b0;
    obs_final = 3'd0; obs_busy_during = 1'b1; obs_unstable = 1'b0;
    obs_ready_bad = 1'b0; obs_timeout = 1'b0;
    for (int k = 0; k < 3; k++) begin obs_err[k] = 2'bxx; obs_cnt[k] = 3'bxxx; end
    @(posedge clk); #1;
    start = 1'b1; sigma = sig; accepted = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; stall = 0; finished = 0; first_valid = 1; prev_hold = 0;
    prev_err = 2'b00; prev_cnt = 3'd0;
    while (cyc < 60 && !finished) begin
      case (mode)
        1: begin
          if (obs_beats == 1 && stall < 4) begin
            accepted = 1'b0; start = 1'b1; sigma = 12'h101; stall++;
          end else begin
            accepted = 1'b1; start = 1'b0;
          end
        end
        2:       accepted = 1'($urandom_range(0, 1));
        default: accepted = 1'b1;
      endcase
      @(negedge clk);
      if (!busy) obs_busy_during = 1'b0;
      if (valid) begin
        if (ready !== first_valid) obs_ready_bad = 1'b1;
        first_valid = 0;
        if (prev_hold && (err !== prev_err || err_count !== prev_cnt)) obs_unstable = 1'b1;
        prev_hold = !accepted;
        prev_err  = err;
        prev_cnt  = err_count;
        if (accepted) begin
          if (obs_beats < 3) begin
            obs_err[obs_beats] = err;
            obs_cnt[obs_beats] = err_count;
          end
          obs_beats++;
        end
      end else if (ready) begin
        obs_ready_bad = 1'b1;
      end
      if (done) begin
        obs_done_cnt++;
        obs_done_beat = obs_beats;
        obs_fail      = fail;
        obs_final     = err_count;
        finished      = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; sigma = sig; accepted = 1'b1;
    @(negedge clk);
    obs_busy_after = busy;
    obs_timeout    = !finished;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; sigma = 12'h000; accepted = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, ready, valid, err, err_count, done, fail} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0", {busy, ready, valid, err, err_count, done, fail});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=000", {busy, valid, done});
    end
    $display("test_reset: busy=%0b valid=%0b err_count=%0d", busy, valid, err_count);
  endtask

  task automatic test_no_errors;
    run_search(12'h001, 0);
    checks++;
    if ({obs_err[0], obs_err[1], obs_err[2]} !== 6'b000000) begin
      errors++; $display("FAIL c1_err got=%b want=000000", {obs_err[0], obs_err[1], obs_err[2]});
    end
    checks++;
    if (obs_beats != 3 || obs_done_cnt != 1 || obs_done_beat != 3 || obs_timeout) begin
      errors++; $display("FAIL c1_beats beats=%0d done=%0d at=%0d want 3/1/3", obs_beats, obs_done_cnt, obs_done_beat);
    end
    checks++;
    if (obs_final !== 3'd0 || obs_fail !== 1'b0 || obs_ready_bad) begin
      errors++; $display("FAIL c1_result cnt=%0d fail=%0b readybad=%0b want 0/0/0", obs_final, obs_fail, obs_ready_bad);
    end
    $display("test_no_errors: err=%b,%b,%b cnt=%0d fail=%0b", obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
  endtask

  task automatic test_single_root;
    run_search(12'h041, 0);
    checks++;
    if (obs_err[1] !== 2'b10 || obs_err[0] !== 2'b00 || obs_err[2] !== 2'b00) begin
      errors++; $display("FAIL c2_err got=%b,%b,%b want 00,10,00", obs_err[0], obs_err[1], obs_err[2]);
    end
    checks++;
    if (obs_final !== 3'd1 || obs_fail !== 1'b0 || obs_done_cnt != 1) begin
      errors++; $display("FAIL c2_result cnt=%0d fail=%0b done=%0d want 1/0/1", obs_final, obs_fail, obs_done_cnt);
    end
    checks++;
    if (obs_busy_after !== 1'b0 || !obs_busy_during) begin
      errors++; $display("FAIL c2_busy after=%0b during=%0b want 0/1", obs_busy_after, obs_busy_during);
    end
    $display("test_single_root: err=%b,%b,%b cnt=%0d fail=%0b", obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
  endtask

  task automatic test_two_roots_masked;
    run_search(12'hC41, 0);
    checks++;
    if (obs_err[0] !== 2'b01 || obs_err[1] !== 2'b00 || obs_err[2] !== 2'b01) begin
      errors++; $display("FAIL c3_err got=%b,%b,%b want 01,00,01", obs_err[0], obs_err[1], obs_err[2]);
    end
    checks++;
    if (obs_cnt[0] !== 3'd1 || obs_cnt[2] !== 3'd2 || obs_final !== 3'd2 || obs_fail !== 1'b0) begin
      errors++; $display("FAIL c3_count b0=%0d final=%0d fail=%0b want 1/2/0", obs_cnt[0], obs_final, obs_fail);
    end
    $display("test_two_roots_masked: err=%b,%b,%b cnt=%0d fail=%0b", obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
  endtask

  task automatic test_parity_root_fail;
    run_search(12'h101, 0);
    checks++;
    if ({obs_err[0], obs_err[1], obs_err[2]} !== 6'd0 || obs_final !== 3'd0) begin
      errors++; $display("FAIL c4_err got=%b cnt=%0d want 0/0", {obs_err[0], obs_err[1], obs_err[2]}, obs_final);
    end
    checks++;
    if (obs_fail !== 1'b1 || obs_done_cnt != 1) begin
      errors++; $display("FAIL c4_fail got=%0b done=%0d want 1/1", obs_fail, obs_done_cnt);
    end
    $display("test_parity_root_fail: cnt=%0d fail=%0b", obs_final, obs_fail);
  endtask

  task automatic test_backpressure;
    run_search(12'hC41, 1);
    checks++;
    if (obs_unstable) begin
      errors++; $display("FAIL c5_stall_stable got=unstable want=stable");
    end
    checks++;
    if (obs_err[0] !== 2'b01 || obs_err[1] !== 2'b00 || obs_err[2] !== 2'b01 ||
        obs_final !== 3'd2 || obs_fail !== 1'b0 || obs_busy_during !== 1'b1) begin
      errors++; $display("FAIL c5_result err=%b,%b,%b cnt=%0d fail=%0b want 01,00,01/2/0",
                         obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
    end
    $display("test_backpressure: err=%b,%b,%b cnt=%0d fail=%0b", obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
  endtask

  task automatic test_reset_abort;
    int seen_done;
    seen_done = 0;
    @(posedge clk); #1;
    start = 1'b1; sigma = 12'hC41; accepted = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    accepted = 1'b0;
    #2;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_setup valid=%0b busy=%0b want 1/1", valid, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, ready, valid, err, err_count, done, fail} !== 10'd0) begin
      errors++; $display("FAIL abort_outputs got=%b want=0", {busy, ready, valid, err, err_count, done, fail});
    end
    accepted = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done || valid) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL abort_no_done got=%0d want=0", seen_done);
    end
    run_search(12'h041, 0);
    checks++;
    if (obs_err[0] !== 2'b00 || obs_err[1] !== 2'b10 || obs_err[2] !== 2'b00 ||
        obs_final !== 3'd1 || obs_fail !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++; $display("FAIL abort_restart err=%b,%b,%b cnt=%0d fail=%0b want 00,10,00/1/0",
                         obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
    end
    $display("test_reset_abort: restart err=%b,%b,%b cnt=%0d", obs_err[0], obs_err[1], obs_err[2], obs_final);
  endtask

  task automatic test_random;
    logic [11:0] sig;
    int sel, e1, e2, s1, s2;
    int bad;
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 2);
      e1 = $urandom_range(0, 14);
      e2 = (e1 + $urandom_range(1, 14)) % 15;
      case (sel)
        0: begin s1 = $urandom_range(0, 15); s2 = $urandom_range(0, 15); end
        1: begin s1 = exp_t[(15 - e1) % 15]; s2 = 0; end
        default: begin
          s1 = exp_t[(15 - e1) % 15] ^ exp_t[(15 - e2) % 15];
          s2 = exp_t[(30 - e1 - e2) % 15];
        end
      endcase
      sig = {s2[3:0], s1[3:0], 4'h1};
      run_search(sig, 2);
      bad = 0;
      for (int n = 0; n < 3; n++) begin
        if (obs_err[n] !== model_err(sig, n) || obs_cnt[n] !== 3'(model_count(sig, n))) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_beats sig=%h got=%b,%b,%b cnt=%0d,%0d,%0d want=%b,%b,%b cnt=%0d,%0d,%0d", sig,
                 obs_err[0], obs_err[1], obs_err[2], obs_cnt[0], obs_cnt[1], obs_cnt[2],
                 model_err(sig, 0), model_err(sig, 1), model_err(sig, 2),
                 model_count(sig, 0), model_count(sig, 1), model_count(sig, 2));
      end
      checks++;
      if (obs_fail !== 1'((model_count(sig, 2) != model_deg(sig))) || obs_done_cnt != 1 ||
          obs_done_beat != 3 || obs_unstable || obs_ready_bad || obs_timeout || obs_busy_after !== 1'b0) begin
        errors++;
        $display("FAIL rand_done sig=%h fail=%0b want=%0b done=%0d at=%0d unstable=%0b readybad=%0b timeout=%0b",
                 sig, obs_fail, (model_count(sig, 2) != model_deg(sig)), obs_done_cnt, obs_done_beat,
                 obs_unstable, obs_ready_bad, obs_timeout);
      end
      $display("test_random[%0d]: sig=%h err=%b,%b,%b cnt=%0d fail=%0b", it, sig,
               obs_err[0], obs_err[1], obs_err[2], obs_final, obs_fail);
    end
  endtask

  initial begin
    int v;
    v = 1;
    log_t[0] = 0;
    for (int k = 0; k < 15; k++) begin
      exp_t[k] = v;
      log_t[v] = k;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 'h13;
    end
    reset = 1'b1; start = 1'b0; sigma = 12'h000; accepted = 1'b0;

    test_reset();
    test_no_errors();
    test_single_root();
    test_two_roots_masked();
    test_parity_root_fail();
    test_backpressure();
    test_reset_abort();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
